// File: rtl/riscv_core_trap_ctrl.sv
// Trap sequencer: picks one exception, interrupt or mret per cycle by priority
// and runs the fixed commit/redirect sequence toward the machine-mode CSRs.
module riscv_core_trap_ctrl #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            i_trap_ctrl_clk,
    input  logic            i_trap_ctrl_rst_n,
    input  logic [XLEN-1:0] i_trap_ctrl_pc_id,
    input  logic [XLEN-1:0] i_trap_ctrl_pc_exe,
    input  logic [XLEN-1:0] i_trap_ctrl_pc_mem,
    input  logic [ILEN-1:0] i_trap_ctrl_instr_id,
    input  logic [ILEN-1:0] i_trap_ctrl_instr_exe,
    input  logic [ILEN-1:0] i_trap_ctrl_instr_mem,
    input  logic            i_trap_ctrl_valid_id,
    input  logic            i_trap_ctrl_valid_exe,
    input  logic            i_trap_ctrl_valid_mem,
    input  logic            i_trap_ctrl_illegal_id,
    input  logic            i_trap_ctrl_ecall_id,
    input  logic            i_trap_ctrl_ebreak_id,
    input  logic            i_trap_ctrl_illegal_exe,
    input  logic            i_trap_ctrl_misaligned_exe,
    input  logic [XLEN-1:0] i_trap_ctrl_exe_target,
    input  logic            i_trap_ctrl_lw_fault_mem,
    input  logic            i_trap_ctrl_sw_fault_mem,
    input  logic [XLEN-1:0] i_trap_ctrl_mem_addr,
    input  logic            i_trap_ctrl_mem_busy,
    input  logic            i_trap_ctrl_mret_wb,
    input  logic            i_trap_ctrl_mstatus_mie,
    input  logic [XLEN-1:0] i_trap_ctrl_mie,
    input  logic [XLEN-1:0] i_trap_ctrl_mip,
    input  logic [XLEN-1:0] i_trap_ctrl_mtvec,
    input  logic [XLEN-1:0] i_trap_ctrl_mepc,
    output logic            o_trap_ctrl_commit,
    output logic [XLEN-1:0] o_trap_ctrl_cause,
    output logic [XLEN-1:0] o_trap_ctrl_epc,
    output logic [XLEN-1:0] o_trap_ctrl_tval,
    output logic [ILEN-1:0] o_trap_ctrl_tinst,
    output logic            o_trap_ctrl_mret_commit,
    output logic            o_trap_ctrl_redirect,
    output logic [XLEN-1:0] o_trap_ctrl_target,
    output logic            o_trap_ctrl_if_flush,
    output logic            o_trap_ctrl_id_flush,
    output logic            o_trap_ctrl_exe_flush,
    output logic            o_trap_ctrl_mem_flush,
    output logic            o_trap_ctrl_stall,
    output logic            o_trap_ctrl_ext_ack
);

    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, MRET} state_t;

    localparam logic [XLEN-1:0] C_EXT = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] C_TMR = {1'b1, (XLEN-1)'(7)};

    state_t state, state_nx;

    logic [XLEN-1:0] cause_q, epc_q, tval_q;
    logic [ILEN-1:0] tinst_q;

    logic mem_sw, mem_lw, exe_ill, exe_mis;
    logic id_ill, id_ebrk, id_ecall;
    logic exc_any, irq_ok, irq_ext, irq_tmr;
    logic take, take_mret;
    logic [XLEN-1:0] cause_nx, epc_nx, tval_nx, irq_epc, base;
    logic [ILEN-1:0] tinst_nx;
    logic [3:0] fl_acc, fl;
    logic unused_bits;

    assign mem_sw   = i_trap_ctrl_valid_mem & i_trap_ctrl_sw_fault_mem;
    assign mem_lw   = i_trap_ctrl_valid_mem & i_trap_ctrl_lw_fault_mem;
    assign exe_ill  = i_trap_ctrl_valid_exe & i_trap_ctrl_illegal_exe;
    assign exe_mis  = i_trap_ctrl_valid_exe & i_trap_ctrl_misaligned_exe;
    assign id_ill   = i_trap_ctrl_valid_id & i_trap_ctrl_illegal_id;
    assign id_ebrk  = i_trap_ctrl_valid_id & i_trap_ctrl_ebreak_id;
    assign id_ecall = i_trap_ctrl_valid_id & i_trap_ctrl_ecall_id;

    assign exc_any = mem_sw | mem_lw | exe_ill | exe_mis
                   | id_ill | id_ebrk | id_ecall;

    assign irq_ok = i_trap_ctrl_mstatus_mie & ~i_trap_ctrl_mem_busy
                  & ~exc_any & ~i_trap_ctrl_mret_wb;
    assign irq_ext = irq_ok & i_trap_ctrl_mie[11] & i_trap_ctrl_mip[11];
    assign irq_tmr = irq_ok & i_trap_ctrl_mie[7] & i_trap_ctrl_mip[7];

    // Interrupts report the oldest live instruction as the resume point.
    assign irq_epc = i_trap_ctrl_valid_mem ? i_trap_ctrl_pc_mem :
                     i_trap_ctrl_valid_exe ? i_trap_ctrl_pc_exe :
                                             i_trap_ctrl_pc_id;

    assign unused_bits = ^{i_trap_ctrl_mie, i_trap_ctrl_mip};

    always_comb begin
        take      = 1'b0;
        take_mret = 1'b0;
        cause_nx  = '0;
        epc_nx    = '0;
        tval_nx   = '0;
        tinst_nx  = '0;
        fl_acc    = 4'b0000;
        if (i_trap_ctrl_mret_wb) begin
            take_mret = 1'b1;
            fl_acc    = 4'b1111;
        end else if (mem_sw | mem_lw) begin
            take     = 1'b1;
            cause_nx = mem_sw ? XLEN'(7) : XLEN'(5);
            epc_nx   = i_trap_ctrl_pc_mem;
            tval_nx  = i_trap_ctrl_mem_addr;
            tinst_nx = i_trap_ctrl_instr_mem;
            fl_acc   = 4'b1111;
        end else if (exe_ill | exe_mis) begin
            take     = 1'b1;
            cause_nx = exe_ill ? XLEN'(2) : XLEN'(0);
            epc_nx   = i_trap_ctrl_pc_exe;
            tval_nx  = exe_ill ? '0 : i_trap_ctrl_exe_target;
            tinst_nx = i_trap_ctrl_instr_exe;
            fl_acc   = 4'b1110;
        end else if (id_ill | id_ebrk | id_ecall) begin
            take     = 1'b1;
            cause_nx = id_ill  ? XLEN'(2) :
                       id_ebrk ? XLEN'(3) : XLEN'(11);
            epc_nx   = i_trap_ctrl_pc_id;
            tinst_nx = i_trap_ctrl_instr_id;
            fl_acc   = 4'b1100;
        end else if (irq_ext | irq_tmr) begin
            take     = 1'b1;
            cause_nx = irq_ext ? C_EXT : C_TMR;
            epc_nx   = irq_epc;
            fl_acc   = 4'b1111;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_mret)
                    state_nx = MRET;
                else if (take)
                    state_nx = COMMIT;
            end
            COMMIT:   state_nx = REDIRECT;
            REDIRECT: state_nx = IDLE;
            MRET:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_trap_ctrl_clk or negedge i_trap_ctrl_rst_n) begin
        if (!i_trap_ctrl_rst_n) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            tinst_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && take && !take_mret) begin
                cause_q <= cause_nx;
                epc_q   <= epc_nx;
                tval_q  <= tval_nx;
                tinst_q <= tinst_nx;
            end
        end
    end

    assign base = {i_trap_ctrl_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        o_trap_ctrl_target = '0;
        unique case (state)
            REDIRECT: begin
                if (i_trap_ctrl_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
                    o_trap_ctrl_target = base + XLEN'({cause_q[5:0], 2'b00});
                else
                    o_trap_ctrl_target = base;
            end
            MRET:    o_trap_ctrl_target = i_trap_ctrl_mepc;
            default: o_trap_ctrl_target = '0;
        endcase
    end

    assign fl = (state == IDLE) ? fl_acc : 4'b1111;

    assign o_trap_ctrl_if_flush     = fl[3];
    assign o_trap_ctrl_id_flush     = fl[2];
    assign o_trap_ctrl_exe_flush    = fl[1];
    assign o_trap_ctrl_mem_flush    = fl[0];
    assign o_trap_ctrl_commit       = (state == COMMIT);
    assign o_trap_ctrl_ext_ack      = (state == COMMIT) && (cause_q == C_EXT);
    assign o_trap_ctrl_mret_commit  = (state == MRET);
    assign o_trap_ctrl_redirect     = (state == REDIRECT) || (state == MRET);
    assign o_trap_ctrl_stall        = (state != IDLE);
    assign o_trap_ctrl_cause        = cause_q;
    assign o_trap_ctrl_epc          = epc_q;
    assign o_trap_ctrl_tval         = tval_q;
    assign o_trap_ctrl_tinst        = tinst_q;

endmodule

// File: tb/tb_riscv_core_trap_ctrl.sv
// Bench for riscv_core_trap_ctrl: directed table, hand sequences and random
// requests checked against a priority-list reference model.
module tb_riscv_core_trap_ctrl;

    typedef struct packed {
        logic [2:0]  valid;  // mem, exe, id
        logic [6:0]  exc;    // sw, lw, ill_exe, mis, ill_id, ebreak, ecall
        logic        mret;
        logic        msie;
        logic [63:0] mie;
        logic [63:0] mip;
        logic        busy;
        logic [63:0] pc_id;
        logic [63:0] pc_exe;
        logic [63:0] pc_mem;
        logic [31:0] in_id;
        logic [31:0] in_exe;
        logic [31:0] in_mem;
        logic [63:0] exe_target;
        logic [63:0] mem_addr;
        logic [63:0] mtvec;
        logic [63:0] mepc;
    } stim_t;

    typedef struct packed {
        logic [1:0]  kind;   // 0 none, 1 trap, 2 mret
        logic [63:0] cause;
        logic [63:0] epc;
        logic [63:0] tval;
        logic [31:0] tinst;
        logic [63:0] target;
        logic [3:0]  flush;  // if, id, exe, mem
        logic        ext;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc_id, pc_exe, pc_mem;
    logic [31:0] instr_id, instr_exe, instr_mem;
    logic        valid_id, valid_exe, valid_mem;
    logic        illegal_id, ecall_id, ebreak_id;
    logic        illegal_exe, misaligned_exe;
    logic [63:0] exe_target;
    logic        lw_fault_mem, sw_fault_mem;
    logic [63:0] mem_addr;
    logic        mem_busy, mret_wb, mstatus_mie;
    logic [63:0] mie, mip, mtvec, mepc;
    logic        commit, mret_commit, redirect, stall, ext_ack;
    logic [63:0] cause, epc, tval, target;
    logic [31:0] tinst;
    logic        if_flush, id_flush, exe_flush, mem_flush;

    int checks = 0;
    int errors = 0;

    riscv_core_trap_ctrl #(.XLEN(64), .ILEN(32)) dut (
        .i_trap_ctrl_clk(clk),
        .i_trap_ctrl_rst_n(rst_n),
        .i_trap_ctrl_pc_id(pc_id),
        .i_trap_ctrl_pc_exe(pc_exe),
        .i_trap_ctrl_pc_mem(pc_mem),
        .i_trap_ctrl_instr_id(instr_id),
        .i_trap_ctrl_instr_exe(instr_exe),
        .i_trap_ctrl_instr_mem(instr_mem),
        .i_trap_ctrl_valid_id(valid_id),
        .i_trap_ctrl_valid_exe(valid_exe),
        .i_trap_ctrl_valid_mem(valid_mem),
        .i_trap_ctrl_illegal_id(illegal_id),
        .i_trap_ctrl_ecall_id(ecall_id),
        .i_trap_ctrl_ebreak_id(ebreak_id),
        .i_trap_ctrl_illegal_exe(illegal_exe),
        .i_trap_ctrl_misaligned_exe(misaligned_exe),
        .i_trap_ctrl_exe_target(exe_target),
        .i_trap_ctrl_lw_fault_mem(lw_fault_mem),
        .i_trap_ctrl_sw_fault_mem(sw_fault_mem),
        .i_trap_ctrl_mem_addr(mem_addr),
        .i_trap_ctrl_mem_busy(mem_busy),
        .i_trap_ctrl_mret_wb(mret_wb),
        .i_trap_ctrl_mstatus_mie(mstatus_mie),
        .i_trap_ctrl_mie(mie),
        .i_trap_ctrl_mip(mip),
        .i_trap_ctrl_mtvec(mtvec),
        .i_trap_ctrl_mepc(mepc),
        .o_trap_ctrl_commit(commit),
        .o_trap_ctrl_cause(cause),
        .o_trap_ctrl_epc(epc),
        .o_trap_ctrl_tval(tval),
        .o_trap_ctrl_tinst(tinst),
        .o_trap_ctrl_mret_commit(mret_commit),
        .o_trap_ctrl_redirect(redirect),
        .o_trap_ctrl_target(target),
        .o_trap_ctrl_if_flush(if_flush),
        .o_trap_ctrl_id_flush(id_flush),
        .o_trap_ctrl_exe_flush(exe_flush),
        .o_trap_ctrl_mem_flush(mem_flush),
        .o_trap_ctrl_stall(stall),
        .o_trap_ctrl_ext_ack(ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [3:0] flushes();
        return {if_flush, id_flush, exe_flush, mem_flush};
    endfunction

    task automatic drive(input stim_t s);
        {valid_mem, valid_exe, valid_id} = s.valid;
        {sw_fault_mem, lw_fault_mem, illegal_exe, misaligned_exe,
         illegal_id, ebreak_id, ecall_id} = s.exc;
        mret_wb = s.mret;  mstatus_mie = s.msie;
        mie = s.mie;       mip = s.mip;       mem_busy = s.busy;
        pc_id = s.pc_id;   pc_exe = s.pc_exe; pc_mem = s.pc_mem;
        instr_id = s.in_id; instr_exe = s.in_exe; instr_mem = s.in_mem;
        exe_target = s.exe_target; mem_addr = s.mem_addr;
        mtvec = s.mtvec;   mepc = s.mepc;
    endtask

    function automatic stim_t quiet(input logic [63:0] tv,
                                    input logic [63:0] ep);
        stim_t s = '0;
        s.mtvec = tv;
        s.mepc  = ep;
        return s;
    endfunction

    function automatic stim_t rand_stim(input logic [63:0] tv,
                                        input logic [63:0] ep);
        stim_t s = quiet(tv, ep);
        s.valid = 3'($urandom);
        for (int i = 0; i < 7; i++)
            s.exc[i] = ($urandom_range(0, 5) == 0);
        s.mret   = ($urandom_range(0, 9) == 0);
        s.msie   = 1'($urandom);
        s.mie[7] = 1'($urandom);   s.mie[11] = 1'($urandom);
        s.mip[7] = 1'($urandom);   s.mip[11] = 1'($urandom);
        s.busy   = ($urandom_range(0, 3) == 0);
        s.pc_id  = {$urandom, $urandom};
        s.pc_exe = {$urandom, $urandom};
        s.pc_mem = {$urandom, $urandom};
        s.in_id  = $urandom; s.in_exe = $urandom; s.in_mem = $urandom;
        s.exe_target = {$urandom, $urandom};
        s.mem_addr   = {$urandom, $urandom};
        return s;
    endfunction

    // Reference: walk the architectural priority list, first live entry wins.
    function automatic exp_t model(input stim_t s);
        logic        act[10];
        logic [63:0] cs[10], ep[10], tv[10];
        logic [31:0] ti[10];
        logic [3:0]  fl[10];
        logic [63:0] iepc;
        logic        ien;
        exp_t e = '0;
        iepc = s.valid[2] ? s.pc_mem : s.valid[1] ? s.pc_exe : s.pc_id;
        ien  = s.msie & ~s.busy;
        act[0] = s.mret;
        act[1] = s.valid[2] & s.exc[6];
        act[2] = s.valid[2] & s.exc[5];
        act[3] = s.valid[1] & s.exc[4];
        act[4] = s.valid[1] & s.exc[3];
        act[5] = s.valid[0] & s.exc[2];
        act[6] = s.valid[0] & s.exc[1];
        act[7] = s.valid[0] & s.exc[0];
        act[8] = ien & s.mie[11] & s.mip[11];
        act[9] = ien & s.mie[7] & s.mip[7];
        cs = '{0, 7, 5, 2, 0, 2, 3, 11, 64'h8000_0000_0000_000B,
               64'h8000_0000_0000_0007};
        ep = '{0, s.pc_mem, s.pc_mem, s.pc_exe, s.pc_exe,
               s.pc_id, s.pc_id, s.pc_id, iepc, iepc};
        tv = '{0, s.mem_addr, s.mem_addr, 0, s.exe_target, 0, 0, 0, 0, 0};
        ti = '{0, s.in_mem, s.in_mem, s.in_exe, s.in_exe,
               s.in_id, s.in_id, s.in_id, 0, 0};
        fl = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'hC, 4'hF, 4'hF};
        for (int i = 0; i < 10; i++) begin
            if (act[i] && e.kind == 0) begin
                e.kind  = (i == 0) ? 2'd2 : 2'd1;
                e.cause = cs[i]; e.epc = ep[i]; e.tval = tv[i];
                e.tinst = ti[i]; e.flush = fl[i]; e.ext = (i == 8);
            end
        end
        if (e.kind == 2)
            e.target = s.mepc;
        else if (s.mtvec[1:0] == 2'b01 && e.cause[63])
            e.target = (s.mtvec & ~64'h3) + 64'(e.cause[5:0]) * 4;
        else
            e.target = s.mtvec & ~64'h3;
        return e;
    endfunction

    // Caller is at posedge+1 in IDLE; returns at posedge+1 in IDLE.
    task automatic run_vec(input stim_t s, input exp_t e, input string tag);
        drive(s);
        @(negedge clk);
        chk({tag, ".acc_flush"}, 64'(flushes()), 64'(e.flush));
        chk({tag, ".acc_stall"}, 64'(stall), 0);
        @(posedge clk); #1;
        if (e.kind == 0) drive(quiet(s.mtvec, s.mepc));
        else             drive(rand_stim(s.mtvec, s.mepc));
        @(negedge clk);
        if (e.kind == 1) begin
            chk({tag, ".commit"}, 64'(commit), 1);
            chk({tag, ".cause"}, cause, e.cause);
            chk({tag, ".epc"}, epc, e.epc);
            chk({tag, ".tval"}, tval, e.tval);
            chk({tag, ".tinst"}, 64'(tinst), 64'(e.tinst));
            chk({tag, ".ext_ack"}, 64'(ext_ack), 64'(e.ext));
            chk({tag, ".c_redirect"}, 64'(redirect), 0);
            chk({tag, ".c_flush"}, 64'(flushes()), 64'hF);
            chk({tag, ".c_stall"}, 64'(stall), 1);
        end else if (e.kind == 2) begin
            chk({tag, ".mret_commit"}, 64'(mret_commit), 1);
            chk({tag, ".m_redirect"}, 64'(redirect), 1);
            chk({tag, ".m_target"}, target, e.target);
            chk({tag, ".m_commit"}, 64'(commit), 0);
            chk({tag, ".m_flush"}, 64'(flushes()), 64'hF);
        end else begin
            chk({tag, ".n_commit"}, 64'(commit), 0);
            chk({tag, ".n_stall"}, 64'(stall), 0);
        end
        @(posedge clk); #1;
        drive(quiet(s.mtvec, s.mepc));
        if (e.kind == 1) begin
            @(negedge clk);
            chk({tag, ".redirect"}, 64'(redirect), 1);
            chk({tag, ".target"}, target, e.target);
            chk({tag, ".r_commit"}, 64'(commit), 0);
            chk({tag, ".r_stall"}, 64'(stall), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, ".idle_stall"}, 64'(stall), 0);
        chk({tag, ".idle_redirect"}, 64'(redirect), 0);
        @(posedge clk); #1;
    endtask

    vec_t  tbl[6];
    stim_t s;
    exp_t  e;

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        // ecall in ID, direct mtvec
        tbl[0].s = quiet(64'h8000_0000, 0);
        tbl[0].s.valid = 3'b001; tbl[0].s.exc = 7'b0000001;
        tbl[0].s.pc_id = 64'h100; tbl[0].s.in_id = 32'h0000_0073;
        tbl[0].e = '{kind: 1, cause: 11, epc: 64'h100, tval: 0,
                     tinst: 32'h0000_0073, target: 64'h8000_0000,
                     flush: 4'hC, ext: 0};
        // vectored timer interrupt
        tbl[1].s = quiet(64'h8000_0001, 0);
        tbl[1].s.valid = 3'b100; tbl[1].s.pc_mem = 64'h200;
        tbl[1].s.msie = 1; tbl[1].s.mie = 64'h80; tbl[1].s.mip = 64'h80;
        tbl[1].e = '{kind: 1, cause: 64'h8000_0000_0000_0007, epc: 64'h200,
                     tval: 0, tinst: 0, target: 64'h8000_001C,
                     flush: 4'hF, ext: 0};
        // store fault beats EXE illegal and ID ecall
        tbl[2].s = quiet(64'h8000_0000, 0);
        tbl[2].s.valid = 3'b111; tbl[2].s.exc = 7'b1010001;
        tbl[2].s.pc_mem = 64'h400; tbl[2].s.in_mem = 32'h00A5_2023;
        tbl[2].s.mem_addr = 64'h1003;
        tbl[2].e = '{kind: 1, cause: 7, epc: 64'h400, tval: 64'h1003,
                     tinst: 32'h00A5_2023, target: 64'h8000_0000,
                     flush: 4'hF, ext: 0};
        // mret beats illegal in ID
        tbl[3].s = quiet(64'h8000_0000, 64'h340);
        tbl[3].s.mret = 1; tbl[3].s.valid = 3'b001;
        tbl[3].s.exc = 7'b0000100;
        tbl[3].e = '{kind: 2, cause: 0, epc: 0, tval: 0, tinst: 0,
                     target: 64'h340, flush: 4'hF, ext: 0};
        // misaligned branch target in EXE
        tbl[4].s = quiet(64'h9000_0002, 0);
        tbl[4].s.valid = 3'b010; tbl[4].s.exc = 7'b0001000;
        tbl[4].s.pc_exe = 64'h500; tbl[4].s.in_exe = 32'h0000_006F;
        tbl[4].s.exe_target = 64'h1002;
        tbl[4].e = '{kind: 1, cause: 0, epc: 64'h500, tval: 64'h1002,
                     tinst: 32'h0000_006F, target: 64'h9000_0000,
                     flush: 4'hE, ext: 0};
        // ecall with no live ID instruction is ignored
        tbl[5].s = quiet(64'h8000_0000, 0);
        tbl[5].s.exc = 7'b0000001; tbl[5].s.pc_id = 64'h600;
        tbl[5].e = '0;

        rst_n = 1'b0;
        drive(quiet(0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.commit", 64'(commit), 0);
        chk("rst.redirect", 64'(redirect), 0);
        chk("rst.stall", 64'(stall), 0);
        chk("rst.cause", cause, 0);
        chk("rst.target", target, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i].s, tbl[i].e, $sformatf("tbl%0d", i));

        // external interrupt deferred while memory busy
        s = quiet(64'h8000_0000, 0);
        s.msie = 1; s.mie = 64'h800; s.mip = 64'h800; s.busy = 1;
        s.valid = 3'b010; s.pc_exe = 64'h300;
        drive(s);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy.flush", 64'(flushes()), 0);
            chk("busy.stall", 64'(stall), 0);
            @(posedge clk); #1;
        end
        s.busy = 0;
        drive(s);
        @(negedge clk);
        chk("busy.acc_flush", 64'(flushes()), 64'hF);
        @(posedge clk); #1;
        drive(quiet(s.mtvec, 0));
        @(negedge clk);
        chk("busy.commit", 64'(commit), 1);
        chk("busy.cause", cause, 64'h8000_0000_0000_000B);
        chk("busy.epc", epc, 64'h300);
        chk("busy.ext_ack", 64'(ext_ack), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy.redirect", 64'(redirect), 1);
        @(posedge clk); #1;

        // async reset during COMMIT
        s = quiet(64'h8000_0000, 0);
        s.valid = 3'b001; s.exc = 7'b0000010; s.pc_id = 64'h700;
        drive(s);
        @(posedge clk); #1;
        chk("rstc.commit_pre", 64'(commit), 1);
        drive(quiet(64'h8000_0000, 0));
        rst_n = 1'b0;
        #1;
        chk("rstc.commit", 64'(commit), 0);
        chk("rstc.stall", 64'(stall), 0);
        chk("rstc.redirect", 64'(redirect), 0);
        chk("rstc.cause", cause, 0);
        chk("rstc.flush", 64'(flushes()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstc.after_redirect", 64'(redirect), 0);
            chk("rstc.after_commit", 64'(commit), 0);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            s = rand_stim({$urandom, 28'($urandom), 2'($urandom), 2'b00}
                          | 64'($urandom_range(0, 3)), {$urandom, $urandom});
            e = model(s);
            run_vec(s, e, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
